// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply / divide / modulo, one result bit per cycle (shift-add, restoring).
// Optional MULDIV_DIV0_FAST_EN: divide-by-zero skips RUN and completes in the cycle after accept.
module muldiv_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             dz,
  output logic             stall
);

  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_MOD = 4'b1010;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   acc_hi, hi_nxt;
  logic [WIDTH-1:0] acc_lo, lo_nxt;
  logic             valid_op, accept, fast_div0, last_step;

  assign valid_op  = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  assign accept    = (state == IDLE) && start && valid_op;
  assign last_step = (state == RUN) && (cnt == CW'(1));

`ifdef MULDIV_DIV0_FAST_EN
  assign fast_div0 = (op != OP_MUL) && (b == '0);
`else
  assign fast_div0 = 1'b0;
`endif

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign stall = accept || (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast_div0 ? DONE : RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration step. MUL: {acc_hi,acc_lo} is the partial product with the
  // multiplier shifting out of acc_lo. DIV/MOD: acc_hi is the partial remainder,
  // acc_lo shifts the dividend out and the quotient in.
  logic [WIDTH:0] mul_sum, div_shift, div_trial;
  always_comb begin
    mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
    hi_nxt    = '0;
    lo_nxt    = '0;
    if (op_q == OP_MUL) begin
      hi_nxt = {1'b0, mul_sum[WIDTH:1]};
      lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (div_shift >= {1'b0, b_q}) begin
      hi_nxt = div_trial;
      lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt = div_shift;
      lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      result <= '0;
      hi     <= '0;
      dz     <= 1'b0;
    end else if (accept) begin
      op_q   <= op;
      a_q    <= a;
      b_q    <= b;
      cnt    <= CW'(WIDTH);
      acc_hi <= '0;
      acc_lo <= (op == OP_MUL) ? b : a;
      if (fast_div0) begin
        // Same outcome a full restoring pass would give with a zero divisor.
        cnt    <= '0;
        result <= (op == OP_DIV) ? '1 : a;
        hi     <= '0;
        dz     <= 1'b1;
      end
    end else if (state == RUN) begin
      cnt    <= cnt - CW'(1);
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      if (last_step) begin
        if (op_q == OP_MUL) begin
          result <= lo_nxt;
          hi     <= hi_nxt[WIDTH-1:0];
          dz     <= 1'b0;
        end else begin
          result <= (op_q == OP_DIV) ? lo_nxt : hi_nxt[WIDTH-1:0];
          hi     <= '0;
          dz     <= (b_q == '0);
        end
      end
    end
  end

endmodule
